// File: rtl/mode_display_pkg.sv
// Shared types and helpers for the mode/LED display controller.
// Holds the FSM state encoding, the candidate-index width function and the
// count-to-LED saturation function. Values are handled in a 64-bit container.
package mode_display_pkg;

  typedef enum logic [1:0] {
    VOTE_IDLE = 2'd0,
    VOTE_ACK  = 2'd1,
    RESULT    = 2'd2
  } state_e;

  // Container width for saturation; VOTE_W and LED_W must not exceed this.
  localparam int SAT_W = 64;

  // Index width for n candidates, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clamp val to the largest value representable in led_w bits.
  function automatic logic [SAT_W-1:0] sat_to_width(input logic [SAT_W-1:0] val,
                                                    input int led_w);
    logic [SAT_W-1:0] lim;
    if (led_w >= SAT_W) begin
      return val;
    end
    lim = (SAT_W'(1) << led_w) - SAT_W'(1);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Vote-acknowledge down-counter: load/reload, decrement and clear.
// Latency: count updates on the clock edge after a command; expired_o is
//   combinational from the count register. No backpressure.
// Ports: clk, reset (sync, active-high), load_i (reload ACK_CYCLES-1),
//   clr_i (force zero), dec_i (count down), expired_o (count is zero).
module ack_timer #(
  parameter int ACK_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic clr_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(ACK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // clr wins over load so a mode switch always aborts the flash.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(ACK_CYCLES - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mode_display_ctrl.sv
// Mode/LED controller between the vote-counter bank and the LED bank.
// Latency: all outputs registered, one cycle from sampled inputs.
// Backpressure: none; inputs are sampled every cycle, pulses are never stalled.
// Ports: clk, reset (sync, active-high), mode (0 vote / 1 result),
//   valid_vote_casted (1-cycle pulse), cand_votes (packed counts),
//   cand_button (one bit per candidate), leds, sel_valid, sel_cand, ack_busy.
// Build option: define MODE_DISPLAY_LEADER_EN to show a leader map in result
//   mode while no candidate is latched; otherwise the LEDs stay dark there.
module mode_display_ctrl
  import mode_display_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int VOTE_W     = 8,
  parameter int LED_W      = 8,
  parameter int ACK_CYCLES = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic                             valid_vote_casted,
  input  logic [NUM_CAND*VOTE_W-1:0]       cand_votes,
  input  logic [NUM_CAND-1:0]              cand_button,
  output logic [LED_W-1:0]                 leds,
  output logic                             sel_valid,
  output logic [idx_width(NUM_CAND)-1:0]   sel_cand,
  output logic                             ack_busy
);

  localparam int CIDX_W = idx_width(NUM_CAND);

  state_e              state_q;
  logic [LED_W-1:0]    leds_q;
  logic                sel_valid_q;
  logic [CIDX_W-1:0]   sel_cand_q;
  logic                ack_busy_q;

  logic                ack_expired;
  logic                tmr_load;
  logic                tmr_clr;
  logic                tmr_dec;

  logic                any_btn;
  logic [CIDX_W-1:0]   btn_idx;
  logic [CIDX_W-1:0]   disp_idx;
  logic [VOTE_W-1:0]   disp_count;
  logic [LED_W-1:0]    disp_leds_d;
  logic [LED_W-1:0]    idle_leds_d;

  // ---------------------------------------------------------------------------
  // Acknowledge timer control. A vote in either voting state (re)arms the
  // timer; a mode switch out of VOTE_ACK clears it so RESULT starts clean.
  // ---------------------------------------------------------------------------
  assign tmr_load = !mode && valid_vote_casted &&
                    ((state_q == VOTE_IDLE) || (state_q == VOTE_ACK));
  assign tmr_clr  = mode && (state_q == VOTE_ACK);
  assign tmr_dec  = !mode && !valid_vote_casted && (state_q == VOTE_ACK);

  ack_timer #(
    .ACK_CYCLES (ACK_CYCLES)
  ) u_ack_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .clr_i     (tmr_clr),
    .dec_i     (tmr_dec),
    .expired_o (ack_expired)
  );

  // ---------------------------------------------------------------------------
  // Button priority: scanning downward leaves the lowest pressed index.
  // ---------------------------------------------------------------------------
  always_comb begin
    btn_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (cand_button[i]) begin
        btn_idx = CIDX_W'(i);
      end
    end
  end

  assign any_btn = |cand_button;

  // A fresh press is displayed on the same edge it is latched.
  assign disp_idx    = any_btn ? btn_idx : sel_cand_q;
  assign disp_count  = cand_votes[int'(disp_idx)*VOTE_W +: VOTE_W];
  assign disp_leds_d = LED_W'(sat_to_width(SAT_W'(disp_count), LED_W));

`ifdef MODE_DISPLAY_LEADER_EN
  // Leader map: mark every candidate whose count equals the maximum; only
  // candidates that have an LED of their own can be shown.
  localparam int LEAD_N = (NUM_CAND < LED_W) ? NUM_CAND : LED_W;

  logic [VOTE_W-1:0] max_cnt;

  always_comb begin
    max_cnt = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_votes[i*VOTE_W +: VOTE_W] > max_cnt) begin
        max_cnt = cand_votes[i*VOTE_W +: VOTE_W];
      end
    end
    idle_leds_d = '0;
    for (int i = 0; i < LEAD_N; i++) begin
      if ((max_cnt != '0) && (cand_votes[i*VOTE_W +: VOTE_W] == max_cnt)) begin
        idle_leds_d[i] = 1'b1;
      end
    end
  end
`else
  assign idle_leds_d = '0;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= VOTE_IDLE;
      leds_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_cand_q  <= '0;
      ack_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        VOTE_IDLE: begin
          if (mode) begin
            state_q     <= RESULT;
            leds_q      <= '0;
            sel_valid_q <= 1'b0;
            ack_busy_q  <= 1'b0;
          end else if (valid_vote_casted) begin
            state_q    <= VOTE_ACK;
            leds_q     <= '1;
            ack_busy_q <= 1'b1;
          end else begin
            leds_q     <= '0;
            ack_busy_q <= 1'b0;
          end
        end

        VOTE_ACK: begin
          if (mode) begin
            state_q     <= RESULT;
            leds_q      <= '0;
            sel_valid_q <= 1'b0;
            ack_busy_q  <= 1'b0;
          end else if (!valid_vote_casted && ack_expired) begin
            state_q    <= VOTE_IDLE;
            leds_q     <= '0;
            ack_busy_q <= 1'b0;
          end else begin
            // Either a retrigger or a running flash: keep the LEDs lit.
            leds_q     <= '1;
            ack_busy_q <= 1'b1;
          end
        end

        RESULT: begin
          ack_busy_q <= 1'b0;
          if (!mode) begin
            state_q     <= VOTE_IDLE;
            leds_q      <= '0;
            sel_valid_q <= 1'b0;
          end else if (any_btn) begin
            sel_cand_q  <= btn_idx;
            sel_valid_q <= 1'b1;
            leds_q      <= disp_leds_d;
          end else if (sel_valid_q) begin
            leds_q <= disp_leds_d;
          end else begin
            leds_q <= idle_leds_d;
          end
        end

        default: begin
          state_q     <= VOTE_IDLE;
          leds_q      <= '0;
          sel_valid_q <= 1'b0;
          ack_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign leds      = leds_q;
  assign sel_valid = sel_valid_q;
  assign sel_cand  = sel_cand_q;
  assign ack_busy  = ack_busy_q;

endmodule
